// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that registers the upstream ready.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5,
    parameter int SKID   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [RD_W-1:0]         in_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [RD_W-1:0]         out_rd,
    output logic [1:0]              occupancy
);

    localparam int BUS_W = LANES * DATA_W;

    logic [BUS_W-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
    logic [1:0]        occ_q, occ_d;
    logic              rdy_q, rdy_d;
    logic              out_valid_s, push_s, pop_s;

    assign out_valid_s = (occ_q != 2'd0);
    // With the skid buffer in_ready is a flop, so out_ready never reaches it.
    assign in_ready    = (SKID != 0) ? rdy_q : (!out_valid_s || out_ready);
    assign push_s      = in_valid && in_ready;
    assign pop_s       = out_valid_s && out_ready;

    assign out_valid = out_valid_s;
    assign out_data  = head_data_q;
    assign out_ctrl  = out_valid_s ? head_ctrl_q : {CTRL_W{1'b0}};
    assign out_rd    = head_rd_q;
    assign occupancy = occ_q;

    // Next-state: occupancy, head/skid contents and registered ready
    always_comb begin
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        head_rd_d   = head_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;
        occ_d       = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (SKID != 0) begin
            case (occ_q)
                2'd0: begin
                    if (push_s) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                        head_rd_d   = in_rd;
                        occ_d       = 2'd1;
                    end else begin
                        occ_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                        head_rd_d   = in_rd;
                    end else if (push_s) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_rd_d   = in_rd;
                        occ_d       = 2'd2;
                    end else if (pop_s) begin
                        occ_d = 2'd0;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                        head_rd_d   = skid_rd_q;
                        occ_d       = 2'd1;
                    end else begin
                        occ_d = 2'd2;
                    end
                end
                default: begin
                    occ_d = 2'd0;
                end
            endcase
        end else begin
            if (push_s) begin
                head_data_d = in_data;
                head_ctrl_d = in_ctrl;
                head_rd_d   = in_rd;
                occ_d       = 2'd1;
            end else if (pop_s) begin
                occ_d = 2'd0;
            end else begin
                occ_d = occ_q;
            end
        end
        rdy_d = (occ_d != 2'd2);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_q <= {BUS_W{1'b0}};
            head_ctrl_q <= {CTRL_W{1'b0}};
            head_rd_q   <= {RD_W{1'b0}};
            skid_data_q <= {BUS_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_rd_q   <= {RD_W{1'b0}};
            occ_q       <= 2'd0;
            rdy_q       <= 1'b1;
        end else begin
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            head_rd_q   <= head_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
            occ_q       <= occ_d;
            rdy_q       <= rdy_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid build (4x32) and a single-entry build (2x16)
// checked every cycle against a queue model, plus directed literal checks.
module tb_pipe_stage_skid;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   c;
        logic [4:0]   r;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic [7:0]   a_in_ctrl, a_out_ctrl;
    logic [4:0]   a_in_rd, a_out_rd;
    logic [1:0]   a_occ;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]  b_in_data, b_out_data;
    logic [7:0]   b_in_ctrl, b_out_ctrl;
    logic [4:0]   b_in_rd, b_out_rd;
    logic [1:0]   b_occ;

    pipe_stage_skid #(.DATA_W(32), .LANES(4), .CTRL_W(8), .RD_W(5), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl), .in_rd(a_in_rd),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .out_rd(a_out_rd),
        .occupancy(a_occ)
    );

    pipe_stage_skid #(.DATA_W(16), .LANES(2), .CTRL_W(8), .RD_W(5), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl), .in_rd(b_in_rd),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_rd(b_out_rd),
        .occupancy(b_occ)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t qa[$];
    ent_t qb[$];
    ent_t da, db;
    bit   known = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model view: head of queue is what is shown; when empty the last shown value persists.
    task automatic compare();
        if (!known) return;
        if (qa.size() > 0) da = qa[0];
        if (qb.size() > 0) db = qb[0];
        chk("a_valid", 128'(a_out_valid), 128'(qa.size() > 0));
        chk("a_data",  a_out_data, da.d);
        chk("a_ctrl",  128'(a_out_ctrl), (qa.size() > 0) ? 128'(da.c) : 128'(0));
        chk("a_rd",    128'(a_out_rd), 128'(da.r));
        chk("a_occ",   128'(a_occ), 128'(qa.size()));
        chk("a_ready", 128'(a_in_ready), 128'(qa.size() < 2));
        chk("b_valid", 128'(b_out_valid), 128'(qb.size() > 0));
        chk("b_data",  128'(b_out_data), 128'(db.d[31:0]));
        chk("b_ctrl",  128'(b_out_ctrl), (qb.size() > 0) ? 128'(db.c) : 128'(0));
        chk("b_rd",    128'(b_out_rd), 128'(db.r));
        chk("b_occ",   128'(b_occ), 128'(qb.size()));
        chk("b_ready", 128'(b_in_ready), 128'(qb.size() == 0 || b_out_ready));
    endtask

    // Called just after a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        bit   pa, popa, pb, popb;
        ent_t e;
        #1 compare();
        pa   = a_in_valid && (qa.size() < 2);
        popa = (qa.size() > 0) && a_out_ready;
        pb   = b_in_valid && (qb.size() == 0 || b_out_ready);
        popb = (qb.size() > 0) && b_out_ready;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
            da.d = '0; da.c = '0; da.r = '0;
            db.d = '0; db.c = '0; db.r = '0;
            known = 1'b1;
        end else begin
            if (a_flush) qa.delete();
            else begin
                if (popa) void'(qa.pop_front());
                if (pa) begin
                    e.d = a_in_data; e.c = a_in_ctrl; e.r = a_in_rd;
                    qa.push_back(e);
                end
            end
            if (b_flush) qb.delete();
            else begin
                if (popb) void'(qb.pop_front());
                if (pb) begin
                    e.d = 128'(b_in_data); e.c = b_in_ctrl; e.r = b_in_rd;
                    qb.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_in_data = '0; a_in_ctrl = '0; a_in_rd = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_in_data = '0; b_in_ctrl = '0; b_in_rd = '0;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;

        // Reset then stream
        a_in_valid = 1'b1; a_in_ctrl = 8'h01; a_in_rd = 5'd3; a_in_data = 128'h40;
        tick();
        chk("lit_first_valid", 128'(a_out_valid), 128'd1);
        chk("lit_first_data",  a_out_data, 128'h40);
        chk("lit_first_ctrl",  128'(a_out_ctrl), 128'h01);
        chk("lit_first_rd",    128'(a_out_rd), 128'd3);
        chk("lit_first_occ",   128'(a_occ), 128'd1);
        chk("lit_first_ready", 128'(a_in_ready), 128'd1);
        for (int i = 0; i < 16; i++) begin
            a_in_data = 128'(32'h100 + i);
            tick();
        end
        chk("lit_stream_last", a_out_data, 128'h10F);
        a_in_valid = 1'b0;
        repeat (2) tick();

        // Stall fill
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 128'hA; tick();
        a_in_data = 128'hB; tick();
        chk("lit_fill_occ",   128'(a_occ), 128'd2);
        chk("lit_fill_ready", 128'(a_in_ready), 128'd0);
        chk("lit_fill_head",  a_out_data, 128'hA);
        a_in_data = 128'hC; tick();
        a_out_ready = 1'b1; tick();
        chk("lit_drain_b", a_out_data, 128'hB);
        chk("lit_drain_occ1", 128'(a_occ), 128'd1);
        tick();
        chk("lit_drain_c", a_out_data, 128'hC);
        chk("lit_drain_occ2", 128'(a_occ), 128'd1);
        a_in_valid = 1'b0; tick();
        chk("lit_drain_occ3", 128'(a_occ), 128'd0);

        // Flush with full buffer
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 128'h1; tick();
        a_in_data = 128'h2; tick();
        a_flush = 1'b1; a_in_data = 128'hD; tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("lit_flush_occ",   128'(a_occ), 128'd0);
        chk("lit_flush_valid", 128'(a_out_valid), 128'd0);
        chk("lit_flush_ctrl",  128'(a_out_ctrl), 128'd0);
        chk("lit_flush_ready", 128'(a_in_ready), 128'd1);
        a_out_ready = 1'b1;
        repeat (3) tick();

        // Flush with pop, then flush discarding a push from ONE
        a_in_valid = 1'b1; a_in_data = 128'hE; tick();
        a_in_valid = 1'b0;
        chk("lit_e_head", a_out_data, 128'hE);
        a_flush = 1'b1; tick();
        a_flush = 1'b0;
        chk("lit_flushpop_occ", 128'(a_occ), 128'd0);
        a_in_valid = 1'b1; a_in_data = 128'hF; tick();
        a_out_ready = 1'b0; a_flush = 1'b1; a_in_data = 128'h77; tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (2) tick();

        // Mid-operation reset
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 128'h55; tick();
        a_in_data = 128'h66; tick();
        chk("lit_prerst_occ", 128'(a_occ), 128'd2);
        rst = 1'b1; a_in_valid = 1'b0; tick();
        rst = 1'b0;
        chk("lit_rst_occ",   128'(a_occ), 128'd0);
        chk("lit_rst_valid", 128'(a_out_valid), 128'd0);
        chk("lit_rst_data",  a_out_data, 128'd0);
        chk("lit_rst_rd",    128'(a_out_rd), 128'd0);
        chk("lit_rst_ready", 128'(a_in_ready), 128'd1);
        a_out_ready = 1'b1;

        // Single-entry build: out_ready toggling with continuous input
        b_in_valid = 1'b1;
        for (int i = 0; i < 44; i++) begin
            b_out_ready = (i % 2 == 0);
            b_in_data   = 32'h200 + 32'(i);
            b_in_ctrl   = 8'(i);
            b_in_rd     = 5'(i);
            tick();
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();

        // Random traffic on both builds
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 15) == 0);
            a_in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            a_in_ctrl   = 8'($urandom());
            a_in_rd     = 5'($urandom());
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 1) != 0);
            b_flush     = ($urandom_range(0, 15) == 0);
            b_in_data   = $urandom();
            b_in_ctrl   = 8'($urandom());
            b_in_rd     = 5'($urandom());
            tick();
        end
        rst = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
